// File: rtl/us_icmp_pkg.sv
// us_icmp_pkg: ICMP constants, FSM encoding and payload/checksum
// helpers shared by the ping generator and the reply path.
package us_icmp_pkg;

  localparam logic [7:0] ECHO_REQ   = 8'h08;
  localparam logic [7:0] ECHO_REPLY = 8'h00;

  localparam int TIMEOUT_DEFAULT = 156250000;
  localparam int PAYLOAD_DEFAULT = 1472;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_HDR,
    ST_DATA,
    ST_WAIT
  } state_t;

  function automatic logic [63:0] payload_beat(
    input logic [7:0] base
  );
    logic [63:0] d;
    for (int j = 0; j < 8; j++)
      d[8*j +: 8] = base + 8'(j);
    return d;
  endfunction

  // rem counts the bytes still owed, this beat included
  function automatic logic [7:0] keep_for(
    input logic [10:0] rem
  );
    logic [8:0] k;
    k = (9'd1 << rem[2:0]) - 9'd1;
    if (rem >= 11'd8)
      return 8'hFF;
    return k[7:0];
  endfunction

  function automatic logic [63:0] mask_beat(
    input logic [63:0] d,
    input logic [7:0]  keep
  );
    logic [63:0] m;
    for (int j = 0; j < 8; j++)
      m[8*j +: 8] = keep[j] ? d[8*j +: 8] : 8'h00;
    return m;
  endfunction

  function automatic logic [63:0] be_words(
    input logic [63:0] d
  );
    logic [63:0] w;
    for (int m = 0; m < 4; m++)
      w[16*m +: 16] = {d[16*m +: 8], d[16*m+8 +: 8]};
    return w;
  endfunction

endpackage

// File: rtl/us_icmp_csum_acc.sv
// us_icmp_csum_acc: adds four 16-bit words to a running
// ones'-complement sum and folds the carries back in.
module us_icmp_csum_acc (
  input  logic [15:0] acc,
  input  logic [63:0] words,
  output logic [15:0] sum
);

  logic [18:0] raw;
  logic [16:0] f1;

  always_comb begin
    raw = {3'b000, acc}
        + {3'b000, words[15:0]}
        + {3'b000, words[31:16]}
        + {3'b000, words[47:32]}
        + {3'b000, words[63:48]};
    f1  = {1'b0, raw[15:0]} + {14'd0, raw[18:16]};
    sum = f1[15:0] + {15'd0, f1[16]};
  end

endmodule

// File: rtl/us_icmp_ping.sv
// us_icmp_ping: ICMP echo request generator with reply matching
// and round-trip measurement on 64-bit AXI-stream.
module us_icmp_ping
  import us_icmp_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int PAYLOAD_MAX    = PAYLOAD_DEFAULT
) (
  input  logic        tx_axis_aclk,
  input  logic        tx_axis_aresetn,
  input  logic        ping_start,
  input  logic [15:0] ping_identifier,
  input  logic [10:0] ping_payload_len,
  output logic [63:0] icmp_tx_axis_tdata,
  output logic [7:0]  icmp_tx_axis_tkeep,
  output logic        icmp_tx_axis_tvalid,
  output logic        icmp_tx_axis_tlast,
  input  logic        icmp_tx_axis_tready,
  input  logic [63:0] ip_rx_axis_tdata,
  input  logic [7:0]  ip_rx_axis_tkeep,
  input  logic        ip_rx_axis_tvalid,
  input  logic        ip_rx_axis_tlast,
  input  logic        ip_rx_axis_tuser,
  output logic        ping_busy,
  output logic        ping_done,
  output logic        ping_timeout,
  output logic [31:0] ping_rtt,
  output logic [15:0] ping_seq
);

  localparam logic [10:0] LEN_MAX = 11'(PAYLOAD_MAX);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nx;
  logic [15:0] seq, id_q, acc, acc_nx, csum;
  logic [10:0] len_q, len_in;
  logic [8:0]  nbeats, calc_cnt, tx_cnt, tx_nx;
  logic        const_done;
  logic [31:0] rtt_cnt, wait_cnt;
  logic        in_frame, cand;
  logic        hs, calc_pay, calc_fin;
  logic        hdr_ok, match, to_hit;
  logic [63:0] calc_words, pay;
  logic        unused_keep;

  assign unused_keep = ^ip_rx_axis_tkeep;
  assign ping_busy   = (state != ST_IDLE);

  always_comb begin
    len_in = (ping_payload_len > LEN_MAX) ?
             LEN_MAX : ping_payload_len;
    hs       = icmp_tx_axis_tvalid & icmp_tx_axis_tready;
    calc_pay = calc_cnt < nbeats;
    calc_fin = !calc_pay && const_done;
    pay = mask_beat(
      payload_beat(8'({calc_cnt, 3'b000})),
      keep_for(11'(len_q - {calc_cnt, 3'b000})));
    calc_words = calc_pay ? be_words(pay) :
                 {16'h0000, seq, id_q, 16'h0800};
    csum  = ~acc;
    tx_nx = tx_cnt + 9'd1;
    hdr_ok = (ip_rx_axis_tdata[7:0] == ECHO_REPLY)
          && (ip_rx_axis_tdata[15:8] == 8'h00)
          && ({ip_rx_axis_tdata[39:32],
               ip_rx_axis_tdata[47:40]} == id_q)
          && ({ip_rx_axis_tdata[55:48],
               ip_rx_axis_tdata[63:56]} == seq);
    match = (state == ST_WAIT) && ip_rx_axis_tvalid
         && ip_rx_axis_tlast && !ip_rx_axis_tuser
         && (in_frame ? cand : hdr_ok);
    to_hit = (state == ST_WAIT) && (wait_cnt == TO_LAST);
  end

  us_icmp_csum_acc u_csum (
    .acc   (acc),
    .words (calc_words),
    .sum   (acc_nx)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (ping_start) state_nx = ST_CALC;
      ST_CALC: if (calc_fin) state_nx = ST_HDR;
      ST_HDR:
        if (hs)
          state_nx = (len_q == 11'd0) ? ST_WAIT : ST_DATA;
      ST_DATA:
        if (hs && icmp_tx_axis_tlast) state_nx = ST_WAIT;
      ST_WAIT:
        if (match || to_hit) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge tx_axis_aclk or negedge tx_axis_aresetn) begin
    if (!tx_axis_aresetn) state <= ST_IDLE;
    else                  state <= state_nx;
  end

  always_ff @(posedge tx_axis_aclk or negedge tx_axis_aresetn) begin
    if (!tx_axis_aresetn) begin
      seq                 <= '0;
      id_q                <= '0;
      len_q               <= '0;
      nbeats              <= '0;
      calc_cnt            <= '0;
      const_done          <= 1'b0;
      acc                 <= '0;
      tx_cnt              <= '0;
      icmp_tx_axis_tdata  <= '0;
      icmp_tx_axis_tkeep  <= '0;
      icmp_tx_axis_tvalid <= 1'b0;
      icmp_tx_axis_tlast  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: if (ping_start) begin
          seq        <= seq + 16'd1;
          id_q       <= ping_identifier;
          len_q      <= len_in;
          nbeats     <= 9'(({1'b0, len_in} + 12'd7) >> 3);
          calc_cnt   <= '0;
          const_done <= 1'b0;
          acc        <= '0;
        end
        ST_CALC: begin
          if (calc_pay) begin
            acc      <= acc_nx;
            calc_cnt <= calc_cnt + 9'd1;
          end else if (!const_done) begin
            acc        <= acc_nx;
            const_done <= 1'b1;
          end else begin
            icmp_tx_axis_tdata <= {
              seq[7:0], seq[15:8], id_q[7:0], id_q[15:8],
              csum[7:0], csum[15:8], 8'h00, ECHO_REQ};
            icmp_tx_axis_tkeep  <= 8'hFF;
            icmp_tx_axis_tlast  <= (len_q == 11'd0);
            icmp_tx_axis_tvalid <= 1'b1;
          end
        end
        ST_HDR: if (hs) begin
          if (len_q == 11'd0) begin
            icmp_tx_axis_tvalid <= 1'b0;
            icmp_tx_axis_tlast  <= 1'b0;
          end else begin
            tx_cnt              <= '0;
            icmp_tx_axis_tdata  <= payload_beat(8'h00);
            icmp_tx_axis_tkeep  <= keep_for(len_q);
            icmp_tx_axis_tlast  <= (nbeats == 9'd1);
          end
        end
        ST_DATA: if (hs) begin
          if (icmp_tx_axis_tlast) begin
            icmp_tx_axis_tvalid <= 1'b0;
            icmp_tx_axis_tlast  <= 1'b0;
          end else begin
            tx_cnt <= tx_nx;
            icmp_tx_axis_tdata <=
              payload_beat(8'({tx_nx, 3'b000}));
            icmp_tx_axis_tkeep <=
              keep_for(11'(len_q - {tx_nx, 3'b000}));
            icmp_tx_axis_tlast <= (tx_nx == nbeats - 9'd1);
          end
        end
        default: ;
      endcase
    end
  end

  // RTT runs from the header handshake until the reply lands
  always_ff @(posedge tx_axis_aclk or negedge tx_axis_aresetn) begin
    if (!tx_axis_aresetn) begin
      rtt_cnt      <= '0;
      wait_cnt     <= '0;
      in_frame     <= 1'b0;
      cand         <= 1'b0;
      ping_done    <= 1'b0;
      ping_timeout <= 1'b0;
      ping_rtt     <= '0;
      ping_seq     <= '0;
    end else begin
      if (state == ST_HDR && hs)
        rtt_cnt <= 32'd1;
      else if ((state == ST_DATA || state == ST_WAIT)
               && rtt_cnt != 32'hFFFF_FFFF)
        rtt_cnt <= rtt_cnt + 32'd1;
      if (state == ST_WAIT) wait_cnt <= wait_cnt + 32'd1;
      else                  wait_cnt <= '0;
      if (ip_rx_axis_tvalid) begin
        in_frame <= !ip_rx_axis_tlast;
        if (!in_frame) cand <= hdr_ok && (state == ST_WAIT);
      end
      ping_done    <= match;
      ping_timeout <= to_hit && !match;
      if (match) begin
        ping_rtt <= rtt_cnt;
        ping_seq <= seq;
      end
    end
  end

endmodule

// File: tb/tb_us_icmp_ping.sv
// tb_us_icmp_ping: scoreboard bench for the ICMP ping generator,
// reply matcher, RTT and timeout paths.
module tb_us_icmp_ping;

  localparam int TO   = 100;
  localparam int PMAX = 44;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ping_start = 1'b0;
  logic [15:0] ping_identifier = '0;
  logic [10:0] ping_payload_len = '0;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid, tlast;
  logic        tready = 1'b1;
  logic [63:0] rx_data = '0;
  logic [7:0]  rx_keep = 8'hFF;
  logic        rx_valid = 1'b0, rx_last = 1'b0, rx_user = 1'b0;
  logic        busy, done, tmo;
  logic [31:0] rtt;
  logic [15:0] pseq;

  us_icmp_ping #(.TIMEOUT_CYCLES(TO), .PAYLOAD_MAX(PMAX)) dut (
    .tx_axis_aclk        (clk),
    .tx_axis_aresetn     (rst_n),
    .ping_start          (ping_start),
    .ping_identifier     (ping_identifier),
    .ping_payload_len    (ping_payload_len),
    .icmp_tx_axis_tdata  (tdata),
    .icmp_tx_axis_tkeep  (tkeep),
    .icmp_tx_axis_tvalid (tvalid),
    .icmp_tx_axis_tlast  (tlast),
    .icmp_tx_axis_tready (tready),
    .ip_rx_axis_tdata    (rx_data),
    .ip_rx_axis_tkeep    (rx_keep),
    .ip_rx_axis_tvalid   (rx_valid),
    .ip_rx_axis_tlast    (rx_last),
    .ip_rx_axis_tuser    (rx_user),
    .ping_busy           (busy),
    .ping_done           (done),
    .ping_timeout        (tmo),
    .ping_rtt            (rtt),
    .ping_seq            (pseq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        hdr;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       mon_e;
  int          checks = 0, failures = 0;
  int          cyc = 0, hdr_edge = 0, last_edge = 0;
  logic [15:0] exp_seq = '0;
  logic [31:0] exp_rtt = '0;
  logic [15:0] exp_pseq = '0;
  bit          toggle_mode = 1'b0;
  bit          stalled = 1'b0;
  logic [72:0] held;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    tready = toggle_mode ? ~tready : 1'b1;
  end

  function automatic logic [63:0] mask64(
    input logic [63:0] d, input logic [7:0] k);
    logic [63:0] m;
    for (int j = 0; j < 8; j++)
      m[8*j +: 8] = k[j] ? d[8*j +: 8] : 8'h00;
    return m;
  endfunction

  // tx monitor: scoreboard pop plus hold-while-stalled check
  always @(negedge clk) begin
    if (!rst_n) stalled = 1'b0;
    else begin
      if (stalled) begin
        checks++;
        if (!tvalid || {tdata, tkeep, tlast} !== held) begin
          failures++;
          $display("FAIL tx_stable: got v=%0b %h/%h/%0b want %h",
                   tvalid, tdata, tkeep, tlast, held);
        end
      end
      if (tvalid && tready) begin
        stalled = 1'b0;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL tx_extra: got %h want no beat", tdata);
        end else begin
          mon_e = exp_q.pop_front();
          if ({mask64(tdata, tkeep), tkeep, tlast} !==
              {mask64(mon_e.data, mon_e.keep), mon_e.keep,
               mon_e.last}) begin
            failures++;
            $display("FAIL tx_beat: got %h/%h/%0b want %h/%h/%0b",
                     tdata, tkeep, tlast,
                     mon_e.data, mon_e.keep, mon_e.last);
          end
          if (mon_e.hdr)  hdr_edge  = cyc + 1;
          if (mon_e.last) last_edge = cyc + 1;
        end
      end else if (tvalid) begin
        stalled = 1'b1;
        held = {tdata, tkeep, tlast};
      end else stalled = 1'b0;
    end
  end

  task automatic push_frame(
    input logic [15:0] id, input logic [15:0] sq, input int len);
    logic [31:0] sum;
    logic [15:0] cs;
    beat_t b;
    int nb, rem;
    sum = 32'h0800 + 32'(id) + 32'(sq);
    for (int i = 0; i < len; i++)
      sum += (i % 2 == 0) ? 32'((i & 255) << 8) : 32'(i & 255);
    while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
    cs = ~sum[15:0];
    b.data = {sq[7:0], sq[15:8], id[7:0], id[15:8],
              cs[7:0], cs[15:8], 8'h00, 8'h08};
    b.keep = 8'hFF;
    b.last = (len == 0);
    b.hdr  = 1'b1;
    exp_q.push_back(b);
    nb = (len + 7) / 8;
    for (int k = 0; k < nb; k++) begin
      for (int j = 0; j < 8; j++) b.data[8*j +: 8] = 8'(8*k + j);
      rem = len - 8*k;
      b.keep = (rem >= 8) ? 8'hFF : 8'((1 << rem) - 1);
      b.last = (k == nb - 1);
      b.hdr  = 1'b0;
      exp_q.push_back(b);
    end
  endtask

  task automatic start_ping(input logic [15:0] id, input int len);
    @(posedge clk); #1;
    ping_start = 1'b1;
    ping_identifier = id;
    ping_payload_len = 11'(len);
    exp_seq++;
    push_frame(id, exp_seq, (len > PMAX) ? PMAX : len);
    @(posedge clk); #1;
    ping_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int n = 0;
    while (busy && n < budget) begin @(negedge clk); n++; end
    ok = !busy;
  endtask

  task automatic wait_drained(input int budget, output bit ok);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk); n++;
    end
    ok = (exp_q.size() == 0);
  endtask

  task automatic send_beat(
    input logic [63:0] d, input logic l, input logic u);
    rx_data = d; rx_last = l; rx_user = u; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_last = 1'b0; rx_user = 1'b0;
  endtask

  function automatic logic [63:0] reply_hdr(
    input logic [15:0] id, input logic [15:0] sq);
    return {sq[7:0], sq[15:8], id[7:0], id[15:8],
            16'h5a5a, 8'h00, 8'h00};
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, tvalid, tlast, done, tmo} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b want 00000",
               {busy, tvalid, tlast, done, tmo});
    end
    checks++;
    if ({tdata, tkeep} !== 72'd0) begin
      failures++;
      $display("FAIL reset_tx: got %h/%h want 0", tdata, tkeep);
    end
    checks++;
    if ({rtt, pseq} !== 48'd0) begin
      failures++;
      $display("FAIL reset_stat: got %h/%h want 0", rtt, pseq);
    end
    rst_n = 1'b1;
    exp_seq = '0;
  endtask

  task automatic test_rtt;
    bit ok;
    int h;
    start_ping(16'h4d7c, 8);
    wait_drained(60, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rtt_tx: got %0d beats left want 0", exp_q.size());
    end
    h = hdr_edge;
    do begin @(posedge clk); #1; end while (cyc < h + 38);
    send_beat(reply_hdr(16'h4d7c, exp_seq), 1'b0, 1'b0);
    send_beat(64'h0706050403020100, 1'b1, 1'b0);
    @(negedge clk);
    exp_rtt = 32'd40;
    exp_pseq = exp_seq;
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL rtt_done: got %b want 1", done);
    end
    checks++;
    if (rtt !== exp_rtt) begin
      failures++;
      $display("FAIL rtt_value: got %0d want %0d", rtt, exp_rtt);
    end
    checks++;
    if (pseq !== 16'd1) begin
      failures++;
      $display("FAIL rtt_seq: got %0d want 1", pseq);
    end
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00) begin
      failures++;
      $display("FAIL rtt_pulse: got done/busy=%b want 00",
               {done, busy});
    end
  endtask

  task automatic test_frame(
    input logic [15:0] id, input int len, input bit tog);
    bit ok;
    toggle_mode = tog;
    start_ping(id, len);
    wait_idle(TO + 300, ok);
    toggle_mode = 1'b0;
    checks++;
    if (!ok || exp_q.size() != 0) begin
      failures++;
      $display("FAIL frame_len%0d: got busy=%b left=%0d want idle,0",
               len, busy, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_timeout;
    bit ok, seen_done;
    int n, le;
    start_ping(16'hBEEF, 8);
    wait_drained(60, ok);
    le = last_edge;
    send_beat(reply_hdr(16'hBEEF, exp_seq + 16'd1), 1'b0, 1'b0);
    send_beat(64'h0, 1'b1, 1'b0);
    send_beat(reply_hdr(16'hBEEF, exp_seq), 1'b1, 1'b1);
    n = 0;
    seen_done = 1'b0;
    @(negedge clk);
    while (!tmo && n < TO + 50) begin
      if (done) seen_done = 1'b1;
      @(negedge clk); n++;
    end
    checks++;
    if (!ok || seen_done) begin
      failures++;
      $display("FAIL to_nomatch: got done=%b tx_ok=%b want 0/1",
               seen_done, ok);
    end
    checks++;
    if (!tmo || cyc - le != TO) begin
      failures++;
      $display("FAIL to_latency: got %0d cycles tmo=%b want %0d",
               cyc - le, tmo, TO);
    end
    checks++;
    if (rtt !== exp_rtt || pseq !== exp_pseq) begin
      failures++;
      $display("FAIL to_stats: got %0d/%0d want %0d/%0d",
               rtt, pseq, exp_rtt, exp_pseq);
    end
    @(negedge clk);
    checks++;
    if ({tmo, busy} !== 2'b00) begin
      failures++;
      $display("FAIL to_pulse: got tmo/busy=%b want 00", {tmo, busy});
    end
  endtask

  task automatic test_start_ignored;
    bit ok;
    int n = 0;
    start_ping(16'h5555, 32);
    while (exp_q.size() > 4 && n < 40) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    ping_start = 1'b1;
    ping_identifier = 16'hAAAA;
    ping_payload_len = 11'd3;
    @(posedge clk); #1;
    ping_start = 1'b0;
    wait_idle(TO + 300, ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      failures++;
      $display("FAIL ignore_start: got busy=%b left=%0d want idle,0",
               busy, exp_q.size());
      exp_q.delete();
    end
    test_frame(16'h5555, 5, 1'b0);
  endtask

  task automatic test_reset_mid;
    int n = 0;
    start_ping(16'h6666, 32);
    while (exp_q.size() > 3 && n < 40) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({tvalid, tlast, busy} !== 3'b000) begin
      failures++;
      $display("FAIL reset_mid: got v/l/busy=%b want 000",
               {tvalid, tlast, busy});
    end
    exp_q.delete();
    exp_seq = '0;
    exp_rtt = '0;
    exp_pseq = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    test_frame(16'h6666, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_rtt();
    test_frame(16'h4d7c, 0, 1'b0);
    test_frame(16'h4d7c, 11, 1'b0);
    test_frame(16'h1234, 32, 1'b0);
    test_frame(16'h1234, 32, 1'b1);
    test_timeout();
    test_frame(16'h0F0F, 100, 1'b0);
    test_start_ignored();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
